// File: rtl/rv_encode_pkg.sv
// Shared RV32I encoding definitions for the instruction loader: opcodes,
// instruction-class and loader-state enums.
package rv_encode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Word-sized access; the only width the core's LOAD/STORE path supports.
  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic [2:0] {
    KIND_R      = 3'd0,
    KIND_IALU   = 3'd1,
    KIND_LOAD   = 3'd2,
    KIND_STORE  = 3'd3,
    KIND_BRANCH = 3'd4,
    KIND_JAL    = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/instr_encoder.sv
// Combinational field-to-RV32I encoder; flags immediates that do not fit
// the target format and unknown instruction classes.
module instr_encoder
  import rv_encode_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic [20:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic fits12;
  logic fits13;

  // A value fits N signed bits when every bit above N-1 equals the sign bit.
  assign fits12 = (&imm_i[20:11]) | ~(|imm_i[20:11]);
  assign fits13 = (&imm_i[20:12]) | ~(|imm_i[20:12]);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    word_o    = '0;
    illegal_o = 1'b0;
    case (kind_i)
      KIND_R:
        word_o = {1'b0, funct7b5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
      KIND_IALU: begin
        word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_IALU};
        illegal_o = ~fits12;
      end
      KIND_LOAD: begin
        word_o    = {imm_i[11:0], rs1_i, F3_WORD, rd_i, OP_LOAD};
        illegal_o = ~fits12;
      end
      KIND_STORE: begin
        word_o    = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OP_STORE};
        illegal_o = ~fits12;
      end
      KIND_BRANCH: begin
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], OP_BRANCH};
        illegal_o = ~fits13 | imm_i[0];
      end
      KIND_JAL: begin
        word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        illegal_o = imm_i[0];
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams instruction fields in, encodes them and writes the words
// sequentially into instruction memory through a registered write port.
module instr_encoder_loader
  import rv_encode_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [2:0]             in_kind,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [2:0]             in_funct3,
  input  logic                   in_funct7b5,
  input  logic [20:0]            in_imm,
  output logic                   imem_we,
  output logic [31:0]            imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

  state_e        state_q;
  logic [31:0]   ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          done_q;
  logic          err_q;
  logic [31:0]   enc_word;
  logic          enc_illegal;

  instr_encoder u_encoder (
    .kind_i     (in_kind),
    .rd_i       (in_rd),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .funct3_i   (in_funct3),
    .funct7b5_i (in_funct7b5),
    .imm_i      (in_imm),
    .word_o     (enc_word),
    .illegal_o  (enc_illegal)
  );

  assign count_d = count_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every register samples the
      // pre-edge values regardless of statement order.
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            if (enc_illegal) begin
              err_q   <= 1'b1;
              state_q <= ST_ERR;
            end else begin
              we_q    <= 1'b1;
              addr_q  <= ptr_q;
              wdata_q <= enc_word;
              ptr_q   <= ptr_q + 32'd4;
              count_q <= count_d;
              if (in_last) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else if (count_d == DEPTH_W) begin
                // Memory full without a terminating beat: keep the word, flag it.
                err_q   <= 1'b1;
                state_q <= ST_ERR;
              end
            end
          end
        end
        default: begin
          if (start) begin
            state_q <= ST_LOAD;
            err_q   <= 1'b0;
            count_q <= '0;
            ptr_q   <= BASE_ADDR;
          end else if (state_q == ST_DONE) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign busy       = (state_q == ST_LOAD);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: two instances (DEPTH 64 and 4) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_instr_encoder_loader;

  localparam int DEP_B = 64;
  localparam int DEP_S = 4;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic        in_last;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [20:0] in_imm;

  logic        b_ready, b_we, b_busy, b_done, b_err;
  logic [31:0] b_addr, b_wdata;
  logic [6:0]  b_count;
  logic        s_ready, s_we, s_busy, s_done, s_err;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_encoder_loader #(.DEPTH(DEP_B), .BASE_ADDR(32'h0)) u_big (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_ready(b_ready), .in_last(in_last), .in_kind(in_kind), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7b5(in_funct7b5), .in_imm(in_imm), .imem_we(b_we),
    .imem_addr(b_addr), .imem_wdata(b_wdata), .busy(b_busy), .done(b_done),
    .err(b_err), .count(b_count)
  );

  instr_encoder_loader #(.DEPTH(DEP_S), .BASE_ADDR(32'h0)) u_small (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_ready(s_ready), .in_last(in_last), .in_kind(in_kind), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7b5(in_funct7b5), .in_imm(in_imm), .imem_we(s_we),
    .imem_addr(s_addr), .imem_wdata(s_wdata), .busy(s_busy), .done(s_done),
    .err(s_err), .count(s_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the instruction-format bit placement, using
  // integer shifts on the two's-complement immediate.
  function automatic logic [31:0] ref_word(input int kind, input int rd, input int rs1,
                                           input int rs2, input int f3, input int f7,
                                           input int imm);
    int unsigned u;
    int unsigned w;
    u = imm;
    w = 0;
    case (kind)
      0: w = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
      1: w = ((u & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
      2: w = ((u & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
      3: w = (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
             | ((u & 'h1F) << 7) | 'h23;
      4: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (rs2 << 20)
             | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 'hF) << 8)
             | (((u >> 11) & 1) << 7) | 'h63;
      5: w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21)
             | (((u >> 11) & 1) << 20) | (((u >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic bit ref_legal(input int kind, input int imm);
    case (kind)
      0:       return 1'b1;
      1, 2, 3: return (imm >= -2048) && (imm <= 2047);
      4:       return (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
      5:       return (imm & 1) == 0;
      default: return 1'b0;
    endcase
  endfunction

  int          m_mode[2];
  int          m_count[2];
  logic [31:0] m_ptr[2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wdata[2];
  bit          m_we[2];
  bit          m_done[2];
  bit          m_err[2];

  task automatic model_step(input int i);
    int old;
    int dep;
    int simm;
    old  = m_mode[i];
    dep  = (i == 0) ? DEP_B : DEP_S;
    simm = $signed(in_imm);
    m_we[i]   = 1'b0;
    m_done[i] = 1'b0;
    if (old != M_LOAD) begin
      if (start) begin
        m_mode[i]  = M_LOAD;
        m_err[i]   = 1'b0;
        m_count[i] = 0;
        m_ptr[i]   = 32'h0;
      end else if (old == M_DONE) begin
        m_mode[i] = M_IDLE;
      end
    end else if (in_valid) begin
      if (!ref_legal(int'(in_kind), simm)) begin
        m_err[i]  = 1'b1;
        m_mode[i] = M_ERR;
      end else begin
        m_we[i]    = 1'b1;
        m_addr[i]  = m_ptr[i];
        m_wdata[i] = ref_word(int'(in_kind), int'(in_rd), int'(in_rs1), int'(in_rs2),
                              int'(in_funct3), int'(in_funct7b5), simm);
        m_ptr[i]   = m_ptr[i] + 4;
        m_count[i] = m_count[i] + 1;
        if (in_last) begin
          m_done[i] = 1'b1;
          m_mode[i] = M_DONE;
        end else if (m_count[i] == dep) begin
          m_err[i]  = 1'b1;
          m_mode[i] = M_ERR;
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = M_IDLE; m_count[i] = 0; m_ptr[i] = '0; m_addr[i] = '0;
        m_wdata[i] = '0; m_we[i] = 1'b0; m_done[i] = 1'b0; m_err[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  task automatic check_dut(input int i, input string tag, input logic rdy, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic bsy, input logic dn, input logic er,
                           input logic [31:0] cnt);
    check({tag, "_ready"}, 32'(rdy), 32'(m_mode[i] == M_LOAD));
    check({tag, "_busy"},  32'(bsy), 32'(m_mode[i] == M_LOAD));
    check({tag, "_we"},    32'(we),  32'(m_we[i]));
    check({tag, "_done"},  32'(dn),  32'(m_done[i]));
    check({tag, "_err"},   32'(er),  32'(m_err[i]));
    check({tag, "_count"}, cnt,      32'(m_count[i]));
    if (m_we[i]) begin
      check({tag, "_addr"},  addr,  m_addr[i]);
      check({tag, "_wdata"}, wdata, m_wdata[i]);
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, "big",   b_ready, b_we, b_addr, b_wdata, b_busy, b_done, b_err, 32'(b_count));
    check_dut(1, "small", s_ready, s_we, s_addr, s_wdata, s_busy, s_done, s_err, 32'(s_count));
  end

  // Directed drivers; each returns 1 time unit after the edge that consumed it.
  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic beat(input int kind, input int rd, input int rs1, input int rs2,
                      input int f3, input int f7, input int imm, input bit last);
    in_kind = 3'(kind); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_funct7b5 = 1'(f7); in_imm = 21'(imm);
    in_last = last; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic int gen_imm(input int kind, input bit legal);
    int v;
    case (kind)
      1, 2, 3: v = legal ? int'($urandom_range(0, 4095)) - 2048
                         : (($urandom_range(0, 1) == 1) ? 2048 + int'($urandom_range(0, 900))
                                                        : -2049 - int'($urandom_range(0, 900)));
      4: v = legal ? (int'($urandom_range(0, 4095)) - 2048) * 2
                   : (($urandom_range(0, 1) == 1) ? 4096 : (int'($urandom_range(0, 2000)) * 2 + 1));
      5: v = legal ? int'($urandom & 32'h001F_FFFE) : int'($urandom | 32'h1);
      default: v = int'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    bit long_mode;
    bit legal;
    int k;
    reset_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0;
    in_funct7b5 = 1'b0; in_imm = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(b_we), 0);
    check("rst_addr", b_addr, 0);
    check("rst_wdata", b_wdata, 0);
    check("rst_busy", 32'(b_busy), 0);
    check("rst_err", 32'(b_err), 0);
    check("rst_count", 32'(b_count), 0);
    @(negedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // add x5,x1,x2 as a one-instruction program
    start_pulse();
    check("t1_ready", 32'(b_ready), 1);
    beat(0, 5, 1, 2, 0, 0, 0, 1);
    check("t1_we", 32'(b_we), 1);
    check("t1_addr", b_addr, 32'h0);
    check("t1_wdata", b_wdata, 32'h0020_82B3);
    check("t1_done", 32'(b_done), 1);
    check("t1_count", 32'(b_count), 1);

    // addi / sw (funct3 input ignored) / beq
    start_pulse();
    beat(1, 6, 0, 0, 0, 0, -1, 0);
    check("t2_w0", b_wdata, 32'hFFF0_0313);
    check("t2_a0", b_addr, 32'h0);
    beat(3, 0, 0, 6, 7, 0, 8, 0);
    check("t2_w1", b_wdata, 32'h0060_2423);
    check("t2_a1", b_addr, 32'h4);
    check("t2_done1", 32'(b_done), 0);
    beat(4, 0, 6, 6, 0, 0, -4, 1);
    check("t2_w2", b_wdata, 32'hFE63_0EE3);
    check("t2_a2", b_addr, 32'h8);
    check("t2_done2", 32'(b_done), 1);

    // back-to-back jal x1,+2048
    start_pulse();
    for (int j = 0; j < 3; j++) begin
      beat(5, 1, 0, 0, 0, 0, 2048, j == 2);
      check("t3_we", 32'(b_we), 1);
      check("t3_wdata", b_wdata, 32'h0010_00EF);
      check("t3_count", 32'(b_count), 32'(j + 1));
    end

    // odd branch offset, then restart
    start_pulse();
    beat(4, 0, 1, 2, 0, 0, 3, 0);
    check("t4_we", 32'(b_we), 0);
    check("t4_err", 32'(b_err), 1);
    check("t4_ready", 32'(b_ready), 0);
    start_pulse();
    check("t4_err_clr", 32'(b_err), 0);
    beat(0, 3, 4, 5, 0, 1, 0, 1);
    check("t4_addr", b_addr, 32'h0);
    check("t4_wdata", b_wdata, 32'h4052_01B3);

    // five beats without last; the small instance overflows at four
    start_pulse();
    for (int j = 0; j < 5; j++) begin
      beat(1, j + 1, 0, 0, 0, 0, j, 0);
      if (j < 4) begin
        check("t5_s_we", 32'(s_we), 1);
        check("t5_s_addr", s_addr, 32'(4 * j));
        check("t5_s_err", 32'(s_err), 32'(j == 3));
      end else begin
        check("t5_s_we5", 32'(s_we), 0);
        check("t5_s_count", 32'(s_count), 4);
        check("t5_b_addr5", b_addr, 32'h10);
      end
    end
    beat(0, 0, 0, 0, 0, 0, 0, 1);

    // reset while a beat is being presented
    start_pulse();
    in_kind = 3'd0; in_rd = 5'd7; in_valid = 1'b1; in_last = 1'b0;
    @(negedge clk); #1 reset_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_we", 32'(b_we), 0);
    check("t6_busy", 32'(b_busy), 0);
    check("t6_count", 32'(b_count), 0);
    check("t6_wdata", b_wdata, 0);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // randomized traffic; second half favours long legal programs
    for (int cyc = 0; cyc < 4000; cyc++) begin
      long_mode = (cyc >= 2000);
      start     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      if (!long_mode && $urandom_range(0, 15) == 0) k = 6 + int'($urandom_range(0, 1));
      else k = int'($urandom_range(0, 5));
      legal = long_mode || ($urandom_range(0, 9) != 0);
      in_kind     = 3'(k);
      in_rd       = 5'($urandom);
      in_rs1      = 5'($urandom);
      in_rs2      = 5'($urandom);
      in_funct3   = 3'($urandom);
      in_funct7b5 = 1'($urandom);
      in_imm      = 21'(gen_imm(k, legal));
      in_last     = long_mode ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 9) == 0);
      @(posedge clk); #1;
      if (cyc == 1500) begin
        @(negedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #3 reset_n = 1'b1;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
